riscv_core_decode_ctrl: RTL

Decode-stage controller between fetch and execute in the RV64IMAC core. It accepts 32-bit instructions with their PC over a valid/ready handshake and derives the immediate-format select from the opcode. It drives the immediate extender and registers the instruction, PC, 64-bit immediate and select into a two-entry skid buffer. The skid buffer gives execute full-throughput backpressure, plus flush and illegal-opcode flagging.

---
 rtl/riscv_core_pkg.sv | 65 ++++++
 rtl/riscv_core_decode_ctrl_if.sv | 30 +++
 rtl/riscv_core_immextend.sv | 25 ++
 rtl/riscv_core_decode_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// Shared decode definitions: immediate formats, opcodes, buffer states, entry layout.
package riscv_core_pkg;

    localparam int PKG_XLEN = 64;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_NONE = 3'b111
    } immsrc_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } decctrl_state_e;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] imm;
        immsrc_e             immsrc;
        logic                illegal;
    } entry_t;

    // Unknown opcodes fall into IMM_NONE so the extender yields zero.
    function automatic immsrc_e opcode_immsrc(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_SYSTEM: opcode_immsrc = IMM_I;
            OPC_STORE:             opcode_immsrc = IMM_S;
            OPC_BRANCH:            opcode_immsrc = IMM_B;
            OPC_JAL:               opcode_immsrc = IMM_J;
            OPC_LUI, OPC_AUIPC:    opcode_immsrc = IMM_U;
            default:               opcode_immsrc = IMM_NONE;
        endcase
    endfunction

    function automatic logic opcode_legal(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_SYSTEM,
            OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC,
            OPC_OP, OPC_OP32, OPC_AMO, OPC_FENCE: opcode_legal = 1'b1;
            default:                              opcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_core_decode_ctrl_if.sv
// Fetch-side and execute-side handshake bundle of the decode controller.
interface riscv_core_decode_ctrl_if;
    import riscv_core_pkg::*;

    logic                i_decctrl_flush;
    logic                i_decctrl_valid;
    logic                o_decctrl_ready;
    logic [31:0]         i_decctrl_instr;
    logic [PKG_XLEN-1:0] i_decctrl_pc;
    logic                o_decctrl_valid;
    logic                i_decctrl_ready;
    logic [31:0]         o_decctrl_instr;
    logic [PKG_XLEN-1:0] o_decctrl_pc;
    logic [PKG_XLEN-1:0] o_decctrl_imm;
    logic [2:0]          o_decctrl_immsrc;
    logic                o_decctrl_illegal;

    modport slave (
        input  i_decctrl_flush, i_decctrl_valid, i_decctrl_instr, i_decctrl_pc, i_decctrl_ready,
        output o_decctrl_ready, o_decctrl_valid, o_decctrl_instr, o_decctrl_pc,
               o_decctrl_imm, o_decctrl_immsrc, o_decctrl_illegal
    );

    modport master (
        output i_decctrl_flush, i_decctrl_valid, i_decctrl_instr, i_decctrl_pc, i_decctrl_ready,
        input  o_decctrl_ready, o_decctrl_valid, o_decctrl_instr, o_decctrl_pc,
               o_decctrl_imm, o_decctrl_immsrc, o_decctrl_illegal
    );

endinterface

// File: rtl/riscv_core_immextend.sv
// Sign-extends the immediate field of instr[31:7] according to the format select.
module riscv_core_immextend
    import riscv_core_pkg::*;
(
    input  logic [31:7] i_imm_instr,
    input  immsrc_e     i_imm_src,
    output logic [63:0] o_imm_ext
);

    // Format-dependent bit gather; IMM_NONE and unused codes give zero.
    always_comb begin
        o_imm_ext = '0;
        case (i_imm_src)
            IMM_I:   o_imm_ext = {{52{i_imm_instr[31]}}, i_imm_instr[31:20]};
            IMM_S:   o_imm_ext = {{52{i_imm_instr[31]}}, i_imm_instr[31:25], i_imm_instr[11:7]};
            IMM_B:   o_imm_ext = {{51{i_imm_instr[31]}}, i_imm_instr[31], i_imm_instr[7],
                                  i_imm_instr[30:25], i_imm_instr[11:8], 1'b0};
            IMM_J:   o_imm_ext = {{43{i_imm_instr[31]}}, i_imm_instr[31], i_imm_instr[19:12],
                                  i_imm_instr[20], i_imm_instr[30:21], 1'b0};
            IMM_U:   o_imm_ext = {{32{i_imm_instr[31]}}, i_imm_instr[31:12], 12'b0};
            default: o_imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/riscv_core_decode_ctrl.sv
// Decode-stage controller: opcode classification, immediate extension and a
// two-entry skid buffer between fetch and execute.
//
//   state | meaning
//   EMPTY | no entry held; accepting
//   ONE   | OUT holds an entry; accepting
//   FULL  | OUT and SKID hold entries; fetch stalled
module riscv_core_decode_ctrl
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                     i_decctrl_clk,
    input  logic                     i_decctrl_rst,
    riscv_core_decode_ctrl_if.slave  bus
);

    decctrl_state_e  r_state;
    decctrl_state_e  w_next_state;
    entry_t          r_out;
    entry_t          r_skid;
    entry_t          w_in_entry;
    logic            r_ready;
    logic            w_accept;
    logic            w_drain;
    logic            w_load_out_in;
    logic            w_load_out_skid;
    logic            w_load_skid;
    immsrc_e         w_immsrc;
    logic [XLEN-1:0] w_imm;

    assign w_immsrc = opcode_immsrc(bus.i_decctrl_instr[6:0]);

    riscv_core_immextend u_immextend (
        .i_imm_instr (bus.i_decctrl_instr[31:7]),
        .i_imm_src   (w_immsrc),
        .o_imm_ext   (w_imm)
    );

    // Entry as it would be captured from the fetch side this cycle.
    always_comb begin
        w_in_entry         = '0;
        w_in_entry.instr   = bus.i_decctrl_instr;
        w_in_entry.pc      = bus.i_decctrl_pc;
        w_in_entry.imm     = w_imm;
        w_in_entry.immsrc  = w_immsrc;
        w_in_entry.illegal = ~opcode_legal(bus.i_decctrl_instr[6:0]);
    end

    // r_ready is already low in FULL, so accept needs no state term.
    assign w_accept = bus.i_decctrl_valid && r_ready;
    assign w_drain  = (r_state != EMPTY) && bus.i_decctrl_ready;

    // Next-state and entry-move decisions; flush outranks accept and drain.
    always_comb begin
        w_next_state    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        if (bus.i_decctrl_flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_load_out_in = 1'b1;
                        w_next_state  = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_out_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid  = 1'b1;
                        w_next_state = FULL;
                    end else if (w_drain) begin
                        w_next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        w_load_out_skid = 1'b1;
                        w_next_state    = ONE;
                    end
                end
                default: w_next_state = EMPTY;
            endcase
        end
    end

    // State register; ready is registered from the next state so execute's
    // ready never reaches fetch combinationally.
    always_ff @(posedge i_decctrl_clk) begin
        if (i_decctrl_rst) begin
            r_state <= EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state != FULL);
        end
    end

    // Entry storage: OUT reloads from input or SKID, SKID from input.
    always_ff @(posedge i_decctrl_clk) begin
        if (i_decctrl_rst) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out_in) begin
                r_out <= w_in_entry;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    assign bus.o_decctrl_ready   = r_ready;
    assign bus.o_decctrl_valid   = (r_state != EMPTY);
    assign bus.o_decctrl_instr   = r_out.instr;
    assign bus.o_decctrl_pc      = r_out.pc;
    assign bus.o_decctrl_imm     = r_out.imm;
    assign bus.o_decctrl_immsrc  = r_out.immsrc;
    assign bus.o_decctrl_illegal = r_out.illegal;

endmodule
